// File: rtl/cipher_pkg.sv
// Shared constants and types for the key exchange and stream cipher blocks.
package cipher_pkg;

  localparam logic [7:0] P_PAR     = 8'd227;
  localparam logic [7:0] Q_PAR     = 8'd225;
  localparam logic [7:0] NULL_CHAR = 8'h00;

  typedef enum logic [1:0] {
    ENC = 2'b00,
    DEC = 2'b01
  } mode_e;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;

  typedef struct packed {
    logic [7:0] chr;
    logic       err;
    logic       last;
  } fifo_entry_t;

endpackage

// File: rtl/cipher_mod_arith.sv
// Combinational add/subtract modulo P_PAR for one character; flags characters
// outside the legal alphabet.
module cipher_mod_arith
  import cipher_pkg::*;
(
  input  logic [7:0] c_i,
  input  logic [7:0] k_i,
  input  logic       dir_i,
  output logic [7:0] res_o,
  output logic       illegal_o
);

  logic [8:0] sum;
  logic [7:0] dif;

  always_comb begin
    illegal_o = (c_i >= P_PAR);
    sum = {1'b0, c_i} + {1'b0, k_i};
    if (sum >= {1'b0, P_PAR}) begin
      sum = sum - {1'b0, P_PAR};
    end
    // On borrow the true result lies in 0..226, so 8-bit wrap is exact.
    if (c_i >= k_i) begin
      dif = c_i - k_i;
    end else begin
      dif = c_i + (P_PAR - k_i);
    end
    if (illegal_o) begin
      res_o = NULL_CHAR;
    end else if (dir_i) begin
      res_o = dif;
    end else begin
      res_o = sum[7:0];
    end
  end

endmodule

// File: rtl/stream_cipher.sv
// Key-latching character cipher with valid/ready ports and a 2-entry output FIFO.
// Define STREAM_CIPHER_TERM_FWD_EN to forward the terminator downstream with dout_last.
//
// state    | meaning
// S_IDLE   | waiting for a legal key/mode on key_valid
// S_RUN    | accepting characters with the latched key
// S_DRAIN  | terminator seen, emptying the output FIFO
module stream_cipher
  import cipher_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [7:0] key_in,
  input  logic       key_valid,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_err,
  output logic       dout_last,
  output logic       err_key,
  output logic       busy
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  state_t      state_q, state_d;
  logic [7:0]  key_q, key_d;
  logic        dec_q, dec_d;
  logic        err_key_q, err_key_d;
  fifo_entry_t mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;

  logic        accept, is_term, push, pop, illegal;
  logic [7:0]  arith_res;
  fifo_entry_t push_data, head;

  cipher_mod_arith u_arith (
    .c_i       (din),
    .k_i       (key_q),
    .dir_i     (dec_q),
    .res_o     (arith_res),
    .illegal_o (illegal)
  );

  assign din_ready = (state_q == S_RUN) && ((count_q < DEPTH) || dout_ready);
  assign accept    = din_valid && din_ready;
  assign is_term   = (din == NULL_CHAR);
  assign pop       = dout_valid && dout_ready;

`ifdef STREAM_CIPHER_TERM_FWD_EN
  assign push      = accept;
  assign push_data = is_term ? '{chr: NULL_CHAR, err: 1'b0, last: 1'b1}
                             : '{chr: arith_res, err: illegal, last: 1'b0};
`else
  assign push      = accept && !is_term;
  assign push_data = '{chr: arith_res, err: illegal, last: 1'b0};
`endif

  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    dec_d     = dec_q;
    err_key_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          if ((mode == ENC || mode == DEC) && key_in != 8'h00 && key_in < P_PAR) begin
            key_d   = key_in;
            dec_d   = mode[0];
            state_d = S_RUN;
          end else begin
            err_key_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept && is_term) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Looking at the next count lets IDLE follow the final pop directly.
        if (count_d == 2'd0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      key_q     <= 8'h00;
      dec_q     <= 1'b0;
      err_key_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      dec_q     <= dec_d;
      err_key_q <= err_key_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign dout_valid = (count_q != 2'd0);
  assign dout       = dout_valid ? head.chr : NULL_CHAR;
  assign dout_err   = dout_valid && head.err;
  assign dout_last  = dout_valid && head.last;
  assign err_key    = err_key_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_stream_cipher.sv
// Self-checking bench for stream_cipher: directed scenarios plus randomized
// messages scored against a modular-arithmetic reference model.
module tb_stream_cipher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] key_in = 8'h00;
  logic       key_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       dout_err;
  logic       dout_last;
  logic       err_key;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int m_key = 0;
  bit m_dec = 1'b0;
  bit rnd_rdy = 1'b0;

  // Beats are {last, err, char}.
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  stream_cipher dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .key_in(key_in), .key_valid(key_valid),
    .din(din), .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_err(dout_err),
    .dout_last(dout_last), .err_key(err_key), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) got_q.push_back({dout_last, dout_err, dout});
  end

  function automatic logic [9:0] model(input int c);
    if (c == 0) return 10'h200;
    if (c >= 227) return 10'h100;
    if (m_dec) return {2'b00, 8'((c - m_key + 227) % 227)};
    return {2'b00, 8'((c + m_key) % 227)};
  endfunction

  task automatic load_key(input int k, input logic [1:0] m);
    key_in = 8'(k); mode = m; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    m_key = k; m_dec = m[0];
  endtask

  task automatic send_byte(input logic [7:0] c);
    int n = 0;
    din = c; din_valid = 1'b1;
    forever begin
      if (rnd_rdy) dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (din_ready) break;
      @(posedge clk); #1;
      n++;
      if (n > 300) begin
        tests++; fails++;
        $display("FAIL send_timeout din_ready=%0b required 1", din_ready);
        din_valid = 1'b0;
        return;
      end
    end
`ifdef STREAM_CIPHER_TERM_FWD_EN
    exp_q.push_back(model(int'(c)));
`else
    if (c != 8'h00) exp_q.push_back(model(int'(c)));
`endif
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    din_valid = 1'b0;
    forever begin
      if (rnd_rdy) dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!busy) break;
      @(posedge clk); #1;
      n++;
      if (n > 300) begin
        tests++; fails++;
        $display("FAIL idle_timeout busy=%0b required 0", busy);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    tests++;
    if ({din_ready, dout_valid, dout_err, dout_last, err_key, busy} !== 6'b0 || dout !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs flags=%b dout=%h required 000000/00",
               {din_ready, dout_valid, dout_err, dout_last, err_key, busy}, dout);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || din_ready !== 1'b0) begin
      fails++; $display("FAIL reset_idle busy=%b din_ready=%b required 0/0", busy, din_ready);
    end
  endtask

  task automatic test_basic();
    dout_ready = 1'b1;
    load_key(3, 2'b00);
    tests++;
    if (busy !== 1'b1 || din_ready !== 1'b1) begin
      fails++; $display("FAIL basic_run busy=%b din_ready=%b required 1/1", busy, din_ready);
    end
    din = 8'h41; din_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(10'h044);
    tests++;
    if (dout_valid !== 1'b1 || dout !== 8'h44) begin
      fails++; $display("FAIL basic_latency valid=%b dout=%h required 1/44", dout_valid, dout);
    end
    din = 8'h00;
    @(posedge clk); #1;
    din_valid = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL basic_drain busy=%b required 1", busy);
    end
`ifdef STREAM_CIPHER_TERM_FWD_EN
    exp_q.push_back(10'h200);
    tests++;
    if (dout_valid !== 1'b1 || dout_last !== 1'b1 || dout !== 8'h00) begin
      fails++; $display("FAIL basic_term valid=%b last=%b dout=%h required 1/1/00", dout_valid, dout_last, dout);
    end
`else
    tests++;
    if (dout_valid !== 1'b0) begin
      fails++; $display("FAIL basic_term_consumed valid=%b required 0", dout_valid);
    end
`endif
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL basic_idle busy=%b required 0", busy);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL basic_count got %0d required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL basic_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    load_key(3, 2'b00);
    send_byte(8'hE1); send_byte(8'h00); wait_idle();
    tests++;
    if (got_q.size() < 1 || got_q[0] !== 10'h001) begin
      fails++; $display("FAIL wrap_enc got %h required 001", got_q.size() ? got_q[0] : 10'h3ff);
    end
    got_q.delete(); exp_q.delete();
    load_key(3, 2'b01);
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h00); wait_idle();
    tests++;
    if (got_q.size() < 2 || got_q[0] !== 10'h0E2 || got_q[1] !== 10'h000) begin
      fails++; $display("FAIL wrap_dec got %0d beats first %h required 0e2,000",
                        got_q.size(), got_q.size() ? got_q[0] : 10'h3ff);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL wrap_count got %0d required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL wrap_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal();
    load_key(3, 2'b00);
    send_byte(8'hF0); send_byte(8'h10); send_byte(8'h00); wait_idle();
    tests++;
    if (got_q.size() < 2 || got_q[0] !== 10'h100 || got_q[1] !== 10'h013) begin
      fails++; $display("FAIL illegal_char got %0d beats first %h required 100,013",
                        got_q.size(), got_q.size() ? got_q[0] : 10'h3ff);
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL illegal_count got %0d required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL illegal_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [7:0] data [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int idx = 0;
    int acc = 0;
    bit took;
    load_key(3, 2'b00);
    dout_ready = 1'b0;
    din = data[0]; din_valid = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      took = din_ready;
      if (took) begin acc++; exp_q.push_back(model(int'(data[idx]))); end
      if (dout_valid) begin
        tests++;
        if (dout !== 8'h04) begin fails++; $display("FAIL bp_stable dout=%h required 04", dout); end
      end
      @(posedge clk); #1;
      if (took) begin idx++; din = data[idx]; end
    end
    @(negedge clk);
    tests++;
    if (acc != 2 || din_ready !== 1'b0) begin
      fails++; $display("FAIL bp_accept accepted=%0d din_ready=%b required 2/0", acc, din_ready);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    for (int i = idx; i < 5; i++) send_byte(data[i]);
    send_byte(8'h00);
    wait_idle();
    tests++;
    if (got_q.size() < 5) begin
      fails++; $display("FAIL bp_len got %0d required at least 5", got_q.size());
    end else for (int i = 0; i < 5; i++) begin
      tests++;
      if (got_q[i] !== 10'(i + 4)) begin fails++; $display("FAIL bp_order%0d got %h required %h", i, got_q[i], 10'(i + 4)); end
    end
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL bp_count got %0d required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_key_reject();
    logic [7:0] bad_key [3]  = '{8'h00, 8'h03, 8'hE3};
    logic [1:0] bad_mode [3] = '{2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      key_in = bad_key[i]; mode = bad_mode[i]; key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      tests++;
      if (err_key !== 1'b1 || busy !== 1'b0) begin
        fails++; $display("FAIL reject%0d err_key=%b busy=%b required 1/0", i, err_key, busy);
      end
      @(posedge clk); #1;
      tests++;
      if (err_key !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL reject_pulse%0d err_key=%b busy=%b required 0/0", i, err_key, busy);
      end
    end
  endtask

  task automatic test_lock();
    load_key(3, 2'b00);
    key_in = 8'h0A; mode = 2'b01; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    tests++;
    if (err_key !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL lock_ignore err_key=%b busy=%b required 0/1", err_key, busy);
    end
    send_byte(8'h10); send_byte(8'h00); wait_idle();
    tests++;
    if (got_q.size() < 1 || got_q[0] !== 10'h013) begin
      fails++; $display("FAIL lock_key got %h required 013", got_q.size() ? got_q[0] : 10'h3ff);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    rnd_rdy = 1'b1;
    for (int msg = 0; msg < 8; msg++) begin
      load_key(int'($urandom_range(1, 226)), 2'($urandom_range(0, 1)));
      for (int j = 0; j < int'($urandom_range(1, 10)); j++) send_byte(8'($urandom_range(1, 255)));
      send_byte(8'h00);
      wait_idle();
      tests++;
      if (got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL rand%0d_count got %0d required %0d", msg, got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        tests++;
        if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_beat%0d got %h required %h", msg, i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();
    end
    rnd_rdy = 1'b0;
    dout_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    load_key(3, 2'b00);
    dout_ready = 1'b0;
    send_byte(8'h01); send_byte(8'h02);
    tests++;
    if (dout_valid !== 1'b1 || din_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_full valid=%b din_ready=%b required 1/0", dout_valid, din_ready);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({din_ready, dout_valid, dout_err, dout_last, err_key, busy} !== 6'b0 || dout !== 8'h00) begin
      fails++; $display("FAIL rstmid_outputs flags=%b dout=%h required 000000/00",
                        {din_ready, dout_valid, dout_err, dout_last, err_key, busy}, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    dout_ready = 1'b1; din = 8'h05; din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (dout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0) begin
        fails++; $display("FAIL rstmid_idle%0d valid=%b busy=%b din_ready=%b required 0/0/0", i, dout_valid, busy, din_ready);
      end
      @(posedge clk); #1;
    end
    din_valid = 1'b0;
    load_key(3, 2'b00);
    send_byte(8'h05);
    tests++;
    if (dout_valid !== 1'b1 || dout !== 8'h08) begin
      fails++; $display("FAIL rstmid_restart valid=%b dout=%h required 1/08", dout_valid, dout);
    end
    send_byte(8'h00); wait_idle();
    tests++;
    if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL rstmid_count got %0d required %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      tests++;
      if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rstmid_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_illegal();
    test_backpressure();
    test_key_reject();
    test_lock();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
